// File: rtl/conf_pkg.sv
// rtl/conf_pkg.sv - shared constants for the configuration dispatcher and its slaves
package conf_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_HEADER   = 3'd1;
    localparam logic [2:0] ST_PAYLOAD  = 3'd2;
    localparam logic [2:0] ST_WAIT_ACK = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;
    localparam logic [2:0] ST_ERROR    = 3'd5;

    localparam logic [1:0] ERR_BAD_HEADER  = 2'd0;
    localparam logic [1:0] ERR_CONFIGURED  = 2'd1;
    localparam logic [1:0] ERR_EARLY_ACK   = 2'd2;
    localparam logic [1:0] ERR_ACK_TIMEOUT = 2'd3;

    localparam int TGT_LSB = 0;
    localparam int TGT_MSB = 2;
    localparam int CNT_LSB = 8;
    localparam int CNT_MSB = 15;

    localparam int IDLE_SEL_DEFAULT = 7;
    localparam int END_OF_STREAM_ID = IDLE_SEL_DEFAULT;
    localparam int INITIALIZER_ID   = 2;

endpackage

// File: rtl/conf_dispatcher.sv
// rtl/conf_dispatcher.sv - replays per-target configuration payloads onto the shared sel/conf_bus pair
module conf_dispatcher
    import conf_pkg::*;
#(
    parameter int CONF_WIDTH   = 16,
    parameter int SELECT_WIDTH = 3,
    parameter int NUM_TARGETS  = 7,
    parameter int IDLE_SEL     = IDLE_SEL_DEFAULT,
    parameter int ACK_TIMEOUT  = 64
) (
    input  logic                    conf_clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [CONF_WIDTH-1:0]   s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [NUM_TARGETS-1:0]  conf_ack_vec,
    output logic [SELECT_WIDTH-1:0] sel,
    output logic [CONF_WIDTH-1:0]   conf_bus,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [1:0]              err_code
);

    localparam int SEL_SPAN = 1 << SELECT_WIDTH;
    localparam int CNT_W    = CNT_MSB - CNT_LSB + 1;
    localparam int TMR_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [SELECT_WIDTH-1:0] SEL_IDLE = SELECT_WIDTH'(IDLE_SEL);
    localparam logic [TMR_W-1:0]        TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

    logic [2:0]              state_q, state_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic [SELECT_WIDTH-1:0] tgt_q, tgt_d;
    logic [SELECT_WIDTH-1:0] sel_q, sel_d;
    logic [CONF_WIDTH-1:0]   bus_q, bus_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic [1:0]              err_q, err_d;

    // Pad the ack vector to the full select range so any header id indexes safely.
    logic [SEL_SPAN-1:0]     ack_ext;
    logic [SELECT_WIDTH-1:0] hdr_tgt;
    logic [CNT_W-1:0]        hdr_cnt;
    logic                    accept;

    assign ack_ext = SEL_SPAN'(conf_ack_vec);
    assign hdr_tgt = SELECT_WIDTH'(s_data[TGT_MSB:TGT_LSB]);
    assign hdr_cnt = s_data[CNT_MSB:CNT_LSB];
    assign accept  = s_valid && s_ready;

    assign s_ready  = (state_q == ST_HEADER) || (state_q == ST_PAYLOAD);
    assign busy     = (state_q == ST_HEADER) || (state_q == ST_PAYLOAD) || (state_q == ST_WAIT_ACK);
    assign sel      = sel_q;
    assign conf_bus = bus_q;
    assign done     = done_q;
    assign error    = error_q;
    assign err_code = err_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        timer_d = timer_q;
        tgt_d   = tgt_q;
        sel_d   = SEL_IDLE;
        bus_d   = bus_q;
        done_d  = done_q;
        error_d = error_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    err_d   = ERR_BAD_HEADER;
                    state_d = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (accept) begin
                    if (hdr_tgt == SEL_IDLE) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else if (int'(hdr_tgt) >= NUM_TARGETS || hdr_cnt == '0) begin
                        error_d = 1'b1;
                        err_d   = ERR_BAD_HEADER;
                        state_d = ST_ERROR;
                    end else if (ack_ext[hdr_tgt]) begin
                        error_d = 1'b1;
                        err_d   = ERR_CONFIGURED;
                        state_d = ST_ERROR;
                    end else begin
                        tgt_d   = hdr_tgt;
                        count_d = hdr_cnt;
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                // The header check guaranteed ack was low, so any ack seen here rose mid-payload.
                if (ack_ext[tgt_q]) begin
                    error_d = 1'b1;
                    err_d   = ERR_EARLY_ACK;
                    state_d = ST_ERROR;
                end else if (accept) begin
                    sel_d   = tgt_q;
                    bus_d   = s_data;
                    count_d = count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) begin
                        timer_d = '0;
                        state_d = ST_WAIT_ACK;
                    end
                end
            end
            ST_WAIT_ACK: begin
                // timer 0 is the cycle the last word is on the bus; the slave can only answer after it.
                if (timer_q != '0 && ack_ext[tgt_q]) begin
                    state_d = ST_HEADER;
                end else if (timer_q == TMR_LAST) begin
                    error_d = 1'b1;
                    err_d   = ERR_ACK_TIMEOUT;
                    state_d = ST_ERROR;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge conf_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            timer_q <= '0;
            tgt_q   <= SEL_IDLE;
            sel_q   <= SEL_IDLE;
            bus_q   <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            err_q   <= ERR_BAD_HEADER;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            timer_q <= timer_d;
            tgt_q   <= tgt_d;
            sel_q   <= sel_d;
            bus_q   <= bus_d;
            done_q  <= done_d;
            error_q <= error_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_conf_dispatcher.sv
// tb/tb_conf_dispatcher.sv - directed and randomized checks of conf_dispatcher against a transaction model
module tb_conf_dispatcher;
    import conf_pkg::*;

    localparam int TO = 64;

    logic        conf_clk = 1'b0;
    logic        reset_n  = 1'b1;
    logic        start    = 1'b0;
    logic [15:0] s_data   = '0;
    logic        s_valid  = 1'b0;
    logic        s_ready;
    logic [6:0]  conf_ack_vec = '0;
    logic [2:0]  sel;
    logic [15:0] conf_bus;
    logic        busy, done, error;
    logic [1:0]  err_code;

    conf_dispatcher #(
        .CONF_WIDTH(16), .SELECT_WIDTH(3), .NUM_TARGETS(7), .IDLE_SEL(7), .ACK_TIMEOUT(TO)
    ) dut (
        .conf_clk(conf_clk), .reset_n(reset_n), .start(start),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .conf_ack_vec(conf_ack_vec), .sel(sel), .conf_bus(conf_bus),
        .busy(busy), .done(done), .error(error), .err_code(err_code)
    );

    always #5 conf_clk = ~conf_clk;

    int cyc = 0;
    always @(posedge conf_clk) cyc = cyc + 1;

    typedef struct {
        int          c;
        logic [2:0]  t;
        logic [15:0] d;
    } beat_t;

    beat_t obs_q[$];
    beat_t exp_q[$];

    // Slave-side view: every cycle a slave is addressed is one delivered word.
    always @(negedge conf_clk)
        if (reset_n && sel !== 3'd7) obs_q.push_back('{cyc, sel, conf_bus});

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge conf_clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [15:0] w, input int gap, output int acc);
        s_valid = 1'b0;
        repeat (gap) tick();
        s_data  = w;
        s_valid = 1'b1;
        acc     = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge conf_clk);
            if (s_ready) begin
                tick();
                acc = cyc;
                break;
            end
            tick();
        end
        s_valid = 1'b0;
        if (acc < 0) chk("accept_wait", 0, 1);
    endtask

    task automatic payload(input logic [2:0] t, input logic [15:0] w, input int gap, output int acc);
        send(w, gap, acc);
        exp_q.push_back('{acc, t, w});
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s_cycle%0d", tag, i), obs_q[i].c, exp_q[i].c);
            chk($sformatf("%s_word%0d", tag, i), {obs_q[i].t, obs_q[i].d}, {exp_q[i].t, exp_q[i].d});
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic clear_stream();
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc, hdr_acc, n, nt, d;
        logic [2:0]  t;
        logic [6:0]  used;
        logic [15:0] w;

        // Reset state
        #2 reset_n = 1'b0;
        tick();
        tick();
        chk("rst_sel", sel, 7);
        chk("rst_bus", conf_bus, 0);
        chk("rst_sready", s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_code", err_code, 0);
        reset_n = 1'b1;
        tick();
        clear_stream();

        // Happy path into the initializer
        pulse_start();
        chk("hp_busy", busy, 1);
        chk("hp_sready", s_ready, 1);
        send(16'h0800 | 16'(INITIALIZER_ID), 0, hdr_acc);
        for (int k = 1; k <= 8; k++) payload(3'(INITIALIZER_ID), 16'(k), 0, acc);
        chk("hp_throughput", acc - hdr_acc, 8);
        chk("hp_wait_sready", s_ready, 0);
        tick();
        conf_ack_vec[INITIALIZER_ID] = 1'b1;
        send(16'h0007, 0, acc);
        chk("hp_done", done, 1);
        chk("hp_busy_end", busy, 0);
        chk("hp_error", error, 0);
        check_stream("hp");

        // Backpressure: valid low every other cycle, one gap replaced by an ignored start
        conf_ack_vec = '0;
        pulse_start();
        chk("bp_done_cleared", done, 0);
        send(16'h0802, 0, acc);
        for (int k = 1; k <= 8; k++) begin
            if (k == 5) begin
                pulse_start();
                payload(3'd2, 16'(16'h00A0 + k), 0, acc);
            end else begin
                payload(3'd2, 16'(16'h00A0 + k), (k == 1) ? 0 : 1, acc);
            end
        end
        tick();
        conf_ack_vec[2] = 1'b1;
        send(16'h0007, 0, acc);
        chk("bp_done", done, 1);
        check_stream("bp");

        // Bad header: zero payload count
        conf_ack_vec = '0;
        pulse_start();
        send(16'h0005, 0, acc);
        chk("n0_error", error, 1);
        chk("n0_code", err_code, 0);
        chk("n0_busy", busy, 0);
        chk("n0_sready", s_ready, 0);

        // Bad header: target already configured
        conf_ack_vec[2] = 1'b1;
        pulse_start();
        chk("cfg_error_cleared", error, 0);
        send(16'h0202, 0, acc);
        chk("cfg_error", error, 1);
        chk("cfg_code", err_code, 1);
        conf_ack_vec = '0;
        clear_stream();

        // Early ack after the second word
        pulse_start();
        send(16'h0402, 0, acc);
        payload(3'd2, 16'h1111, 0, acc);
        payload(3'd2, 16'h2222, 0, acc);
        conf_ack_vec[2] = 1'b1;
        tick();
        chk("early_error", error, 1);
        chk("early_code", err_code, 2);
        chk("early_sel", sel, 7);
        chk("early_sready", s_ready, 0);
        check_stream("early");

        // Ack timeout
        conf_ack_vec = '0;
        pulse_start();
        send(16'h0102, 0, acc);
        payload(3'd2, 16'hABCD, 0, acc);
        n = -1;
        for (int i = 1; i <= 3 * TO; i++) begin
            tick();
            if (error === 1'b1) begin
                n = i;
                break;
            end
        end
        chk("to_latency", n, TO);
        chk("to_code", err_code, 3);
        check_stream("to");
        pulse_start();
        chk("to_restart_error", error, 0);
        chk("to_restart_code", err_code, 0);
        chk("to_restart_sready", s_ready, 1);

        // Async reset in the middle of a payload
        send(16'h0404, 0, acc);
        payload(3'd4, 16'h5A5A, 0, acc);
        payload(3'd4, 16'hC3C3, 0, acc);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_sel", sel, 7);
        chk("ar_bus", conf_bus, 0);
        chk("ar_busy", busy, 0);
        chk("ar_sready", s_ready, 0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("ar_idle_sready", s_ready, 0);
        chk("ar_idle_busy", busy, 0);
        clear_stream();
        pulse_start();
        send(16'h0106, 0, acc);
        payload(3'd6, 16'h7E57, 0, acc);
        tick();
        conf_ack_vec[6] = 1'b1;
        send(16'hFFFF, 0, acc);
        chk("ar_done", done, 1);
        check_stream("ar");

        // Randomized multi-target sessions
        for (int s = 0; s < 6; s++) begin
            conf_ack_vec = '0;
            used = '0;
            pulse_start();
            nt = $urandom_range(1, 4);
            for (int j = 0; j < nt; j++) begin
                do t = 3'($urandom_range(0, 6)); while (used[t]);
                used[t] = 1'b1;
                n = $urandom_range(1, 6);
                w = $urandom;
                send({8'(n), w[7:3], t}, $urandom_range(0, 2), acc);
                for (int k = 0; k < n; k++) payload(t, 16'($urandom), $urandom_range(0, 2), acc);
                chk($sformatf("rnd%0d_wait_sready", s), s_ready, 0);
                d = $urandom_range(0, 10);
                repeat (d) tick();
                conf_ack_vec[t] = 1'b1;
            end
            w = $urandom;
            send({w[15:3], 3'd7}, $urandom_range(0, 2), acc);
            chk($sformatf("rnd%0d_done", s), done, 1);
            chk($sformatf("rnd%0d_error", s), error, 0);
            check_stream($sformatf("rnd%0d", s));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conf_dispatcher.md
Name: conf_dispatcher

Overview:
- Upstream feeder for the global controller's configuration slaves (initializer and its sibling config modules).
- Accepts a valid/ready stream of configuration words and decodes per-target headers.
- Replays payload words one per conf_clk cycle on the shared sel/conf_bus pair, then waits for the target's conf_ack before starting the next target.
- Reports done or error to the host-side loader.

Parameters:
- CONF_WIDTH, 16, conf_bus and stream word width; must be >= 16.
- SELECT_WIDTH, 3, width of sel.
- NUM_TARGETS, 7, number of config slaves; ids 0..NUM_TARGETS-1.
- IDLE_SEL, 7, sel value that addresses no slave; also the end-of-stream target id.
- ACK_TIMEOUT, 64, conf_clk cycles allowed between the last payload word and the target's conf_ack.

Ports:
- conf_clk  in  1  configuration clock; all logic on its rising edge.
- reset_n  in  1  reset.
- start  in  1  one-cycle pulse; begins a configuration session; ignored while busy.
- s_data  in  CONF_WIDTH  stream word (header or payload).
- s_valid  in  1  s_data valid.
- s_ready  out  1  word accepted when s_valid && s_ready.
- conf_ack_vec  in  NUM_TARGETS  conf_ack of each slave, indexed by select id.
- sel  out  SELECT_WIDTH  slave select, registered.
- conf_bus  out  CONF_WIDTH  payload word, registered.
- busy  out  1  session in progress.
- done  out  1  sticky; end-of-stream header received.
- error  out  1  sticky; session aborted.
- err_code  out  2  0 bad header, 1 already configured, 2 early ack, 3 ack timeout.

Behaviour:
- Reset (already decided): one clock; reset is asynchronous and active-low (reset_n).
- While reset_n is low, registered outputs are:
  - sel=IDLE_SEL, conf_bus=0, s_ready=0, busy=0, done=0, error=0, err_code=0.
  - State IDLE; count=0; timer=0.
- Reset asserted mid-session aborts immediately to these values.
- Header format:
  - s_data[2:0] = target id.
  - s_data[15:8] = payload word count N.
  - All other bits are ignored.
- States: IDLE, HEADER, PAYLOAD, WAIT_ACK, DONE, ERROR.
- IDLE: s_ready=0. On start: clear done/error/err_code, busy=1, go HEADER.
- HEADER: s_ready=1. On accept, the outcome is checked in this priority order:
  - target==IDLE_SEL -> DONE.
  - target>=NUM_TARGETS or N==0 -> ERROR, code 0.
  - conf_ack_vec[target]==1 -> ERROR, code 1.
  - Otherwise latch target and count=N, go PAYLOAD.
- PAYLOAD:
  - s_ready=1.
  - A word accepted in cycle t drives sel=target and conf_bus=s_data in cycle t+1 only (exactly one cycle).
  - In any cycle without an accept, sel=IDLE_SEL and conf_bus holds its last value.
  - A stalled stream therefore inserts idle cycles that no slave samples.
  - count decrements per accept. The accept that brings count to 0 goes to WAIT_ACK, timer=0.
  - If conf_ack_vec[target] rises while count>0 -> ERROR, code 2.
- WAIT_ACK:
  - s_ready=0, sel=IDLE_SEL, timer increments each cycle.
  - Ack is checked from the cycle after the last word is driven.
  - conf_ack_vec[target]==1 -> HEADER. Ack takes priority over timeout in the same cycle.
  - timer==ACK_TIMEOUT-1 without ack -> ERROR, code 3.
- DONE: busy=0, done=1, s_ready=0. start -> same as IDLE start.
- ERROR: busy=0, error=1, err_code held, s_ready=0, sel=IDLE_SEL. Only start or reset leaves.
- start in any busy state (HEADER, PAYLOAD, WAIT_ACK) is ignored.
- conf_ack_vec bits are level, sticky per slave; they are sampled synchronously and not re-synchronised (same clock domain).
- Throughput: one payload word per cycle with s_valid held high. Header acceptance costs one cycle.

Decomposition:
- Shared package conf_pkg holds:
  - State encoding.
  - err_code constants.
  - Header field positions (TGT_LSB=0, TGT_MSB=2, CNT_LSB=8, CNT_MSB=15).
  - IDLE_SEL default.
  - Slave id constants, including INITIALIZER_ID=2.
- Single module; no sub-module is needed.
- The ack timer is an inline counter; width is clog2(ACK_TIMEOUT).

Test Plan:
- Happy path: start, stream 0x0802 then 8 words 0x0001..0x0008, model slave 2 asserts ack 1 cycle after the 8th word, then 0x0007.
  - Expect sel=2 for exactly 8 cycles, each one cycle after its accept, with matching conf_bus values.
  - Then done=1, busy=0, error=0.
- Backpressure gaps: same stream with s_valid low every other cycle.
  - Expect sel alternating 2/7.
  - Slave model sees the 8 words in order with no duplicates.
- Bad headers:
  - 0x0005 (N=0) -> error=1, err_code=0.
  - 0x0202 with conf_ack_vec[2]=1 at header -> err_code=1.
- Early ack: 0x0402 with ack raised after word 2 -> error, err_code=2, sel=7 the following cycle, s_ready=0.
- Timeout: 0x0102 with the ack never raised.
  - Expect error and err_code=3 exactly ACK_TIMEOUT cycles after entering WAIT_ACK.
  - A second start clears error and re-enters HEADER.
- Async reset: drop reset_n mid-PAYLOAD between clock edges.
  - Expect outputs reset immediately without waiting for an edge.
  - After release, state is IDLE and the first start restarts cleanly.
